rpn_stack_pop: RTL and testbench

- Read side of the RPN operand stack; complements the existing push path, which writes the value at SP and then increments SP.
- On request, pops one or two operands from the stack RAM, presents them as operand_a (top) and operand_b (next), and commits the decremented SP.
- Flags underflow without touching SP.
- Sits between the top-level control FSM, the STACK_POINTER register and the shared RAM read port; the future ALU stage consumes its outputs.

---
 rtl/rpn_stack_pop_pkg.sv | 23 ++
 rtl/rpn_stack_pop_reg.sv | 21 ++
 rtl/rpn_stack_pop.sv | 159 +++++++++++++++
 tb/tb_rpn_stack_pop.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/rpn_stack_pop_pkg.sv
// Shared definitions for the RPN stack pop path: state codes, display glyphs
// and the operand-count helper.
package rpn_stack_pop_pkg;

    // Codes sit above the push FSM's range so both can share one state display.
    typedef enum logic [3:0] {
        S_IDLE   = 4'h8,
        S_CHECK  = 4'h9,
        S_ERR    = 4'hA,
        S_RD_A   = 4'hB,
        S_RD_B   = 4'hC,
        S_COMMIT = 4'hD
    } pop_state_t;

    localparam logic [6:0] SEG_E = 7'b0000110;
    localparam logic [6:0] SEG_R = 7'b0101111;
    localparam logic [6:0] SEG_O = 7'b0100011;

    function automatic logic [1:0] pop_need(input logic two);
        pop_need = two ? 2'd2 : 2'd1;
    endfunction

endpackage

// File: rtl/rpn_stack_pop_reg.sv
// Plain load-enabled register used to hold the popped operands.
module reg_load_enable #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         load,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    // Holds its value until the next load strobe.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            q <= '0;
        end else if (load) begin
            q <= d;
        end
    end

endmodule

// File: rtl/rpn_stack_pop.sv
// Read side of the RPN operand stack: pops one or two operands from the stack
// RAM, reports underflow, and issues the decremented stack pointer.
module rpn_stack_pop
    import rpn_stack_pop_pkg::*;
#(
    parameter int DATA_W      = 8,
    parameter int ADDR_W      = 8,
    parameter int RAM_LATENCY = 1
) (
    input  logic              CLOCK_50,
    input  logic              reset_n,
    input  logic              pop_req,
    input  logic              pop_two,
    input  logic [ADDR_W-1:0] sp,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_rd,
    output logic [ADDR_W-1:0] sp_next,
    output logic              sp_we,
    output logic [DATA_W-1:0] operand_a,
    output logic [DATA_W-1:0] operand_b,
    output logic              busy,
    output logic              done,
    output logic              underflow
);

    localparam logic [1:0]        LAT_LAST = 2'(RAM_LATENCY - 1);
    localparam logic [ADDR_W-1:0] ONE      = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] TWO      = ADDR_W'(2);

    pop_state_t        r_state;
    logic [ADDR_W-1:0] r_sp_l;
    logic              r_two_l;
    logic [1:0]        r_cnt;

    logic [ADDR_W-1:0] w_need;
    logic              w_last;
    logic              w_cap_a;
    logic              w_cap_b;

    // Operand count and capture strobes; the strobe fires on the cycle read data is valid.
    always_comb begin
        w_need  = {{(ADDR_W-2){1'b0}}, pop_need(r_two_l)};
        w_last  = (r_cnt == LAT_LAST);
        w_cap_a = (r_state == S_RD_A) && w_last;
        w_cap_b = (r_state == S_RD_B) && w_last;
    end

    // Pop sequencer; every output is registered alongside the state transition.
    always_ff @(posedge CLOCK_50) begin
        if (!reset_n) begin
            r_state   <= S_IDLE;
            r_sp_l    <= '0;
            r_two_l   <= 1'b0;
            r_cnt     <= 2'd0;
            ram_addr  <= '0;
            ram_rd    <= 1'b0;
            sp_next   <= '0;
            sp_we     <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            underflow <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    done   <= 1'b0;
                    sp_we  <= 1'b0;
                    ram_rd <= 1'b0;
                    if (pop_req) begin
                        r_sp_l    <= sp;
                        r_two_l   <= pop_two;
                        underflow <= 1'b0;
                        busy      <= 1'b1;
                        r_state   <= S_CHECK;
                    end else begin
                        busy <= 1'b0;
                    end
                end
                // Rejecting here is what keeps sp_l-1 / sp_l-2 from wrapping.
                S_CHECK: begin
                    if (r_sp_l < w_need) begin
                        done      <= 1'b1;
                        underflow <= 1'b1;
                        r_state   <= S_ERR;
                    end else begin
                        ram_rd   <= 1'b1;
                        ram_addr <= r_sp_l - ONE;
                        r_cnt    <= 2'd0;
                        r_state  <= S_RD_A;
                    end
                end
                S_ERR: begin
                    done    <= 1'b0;
                    busy    <= 1'b0;
                    r_state <= S_IDLE;
                end
                S_RD_A: begin
                    if (w_last) begin
                        r_cnt <= 2'd0;
                        if (r_two_l) begin
                            ram_addr <= r_sp_l - TWO;
                            r_state  <= S_RD_B;
                        end else begin
                            ram_rd  <= 1'b0;
                            sp_next <= r_sp_l - w_need;
                            sp_we   <= 1'b1;
                            done    <= 1'b1;
                            r_state <= S_COMMIT;
                        end
                    end else begin
                        r_cnt <= r_cnt + 2'd1;
                    end
                end
                S_RD_B: begin
                    if (w_last) begin
                        r_cnt   <= 2'd0;
                        ram_rd  <= 1'b0;
                        sp_next <= r_sp_l - w_need;
                        sp_we   <= 1'b1;
                        done    <= 1'b1;
                        r_state <= S_COMMIT;
                    end else begin
                        r_cnt <= r_cnt + 2'd1;
                    end
                end
                S_COMMIT: begin
                    sp_we   <= 1'b0;
                    done    <= 1'b0;
                    busy    <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    ram_rd  <= 1'b0;
                    sp_we   <= 1'b0;
                    done    <= 1'b0;
                    busy    <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    reg_load_enable #(.W(DATA_W)) u_operand_a (
        .clk     (CLOCK_50),
        .reset_n (reset_n),
        .load    (w_cap_a),
        .d       (ram_rdata),
        .q       (operand_a)
    );

    reg_load_enable #(.W(DATA_W)) u_operand_b (
        .clk     (CLOCK_50),
        .reset_n (reset_n),
        .load    (w_cap_b),
        .d       (ram_rdata),
        .q       (operand_b)
    );

endmodule

// File: tb/tb_rpn_stack_pop.sv
// Randomised bench for rpn_stack_pop: two instances (RAM latency 1 and 3) run
// the same pops against a transaction-level stack model.
module tb_rpn_stack_pop;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       pop_two;
    logic [7:0] sp;
    logic       pop_req_w   [2];
    logic [7:0] rdata_w     [2];
    logic [7:0] ram_addr_w  [2];
    logic       ram_rd_w    [2];
    logic [7:0] sp_next_w   [2];
    logic       sp_we_w     [2];
    logic [7:0] opa_w       [2];
    logic [7:0] opb_w       [2];
    logic       busy_w      [2];
    logic       done_w      [2];
    logic       uf_w        [2];

    logic [7:0] mem [256];
    logic [7:0] a_p1, a_p2;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] exp_a, exp_b;
    logic       exp_uf;

    always #10 clk = ~clk;

    rpn_stack_pop #(.DATA_W(8), .ADDR_W(8), .RAM_LATENCY(1)) u_dut1 (
        .CLOCK_50(clk), .reset_n(reset_n), .pop_req(pop_req_w[0]), .pop_two(pop_two),
        .sp(sp), .ram_rdata(rdata_w[0]), .ram_addr(ram_addr_w[0]), .ram_rd(ram_rd_w[0]),
        .sp_next(sp_next_w[0]), .sp_we(sp_we_w[0]), .operand_a(opa_w[0]),
        .operand_b(opb_w[0]), .busy(busy_w[0]), .done(done_w[0]), .underflow(uf_w[0])
    );

    rpn_stack_pop #(.DATA_W(8), .ADDR_W(8), .RAM_LATENCY(3)) u_dut3 (
        .CLOCK_50(clk), .reset_n(reset_n), .pop_req(pop_req_w[1]), .pop_two(pop_two),
        .sp(sp), .ram_rdata(rdata_w[1]), .ram_addr(ram_addr_w[1]), .ram_rd(ram_rd_w[1]),
        .sp_next(sp_next_w[1]), .sp_we(sp_we_w[1]), .operand_a(opa_w[1]),
        .operand_b(opb_w[1]), .busy(busy_w[1]), .done(done_w[1]), .underflow(uf_w[1])
    );

    // RAM models: latency 1 is data valid in the address cycle, latency 3 two cycles later.
    always_comb begin
        rdata_w[0] = mem[ram_addr_w[0]];
        rdata_w[1] = mem[a_p2];
    end

    always @(posedge clk) begin
        a_p1 <= ram_addr_w[1];
        a_p2 <= a_p1;
    end

    task automatic check_eq(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, got, got, exp, exp);
        end
    endtask

    // One pop transaction; cycle 0 carries pop_req. x0/x1 add extra request
    // pulses per instance, rst_c pulls reset low for that one cycle (-1 = none).
    task automatic run_pop(input logic [7:0] sp_i, input logic two_i,
                           input logic [15:0] x0, input logic [15:0] x1, input int rst_c);
        int done_c [2];
        int we_cnt [2];
        int rd_cnt [2];
        int first_addr [2];
        int last_addr [2];
        logic [7:0] got_a [2], got_b [2], got_sn [2];
        logic got_uf [2], got_busy [2];
        int  need, lat, exp_cyc;
        bit  err;
        logic [7:0] ea, eb;

        need = two_i ? 2 : 1;
        err  = int'(sp_i) < need;
        ea   = err ? exp_a : mem[int'(sp_i) - 1];
        eb   = (err || !two_i) ? exp_b : mem[int'(sp_i) - 2];
        for (int k = 0; k < 2; k++) begin
            done_c[k] = -1; we_cnt[k] = 0; rd_cnt[k] = 0;
            first_addr[k] = -1; last_addr[k] = -1;
        end

        for (int c = 0; c < 14; c++) begin
            pop_req_w[0] = (c == 0) || x0[c];
            pop_req_w[1] = (c == 0) || x1[c];
            pop_two      = two_i;
            sp           = (c == 0) ? sp_i : ~sp_i;
            reset_n      = (c != rst_c);
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                if (sp_we_w[k]) we_cnt[k]++;
                if (ram_rd_w[k]) begin
                    rd_cnt[k]++;
                    if (first_addr[k] < 0) first_addr[k] = int'(ram_addr_w[k]);
                    last_addr[k] = int'(ram_addr_w[k]);
                end
                if (done_w[k] && done_c[k] < 0) begin
                    done_c[k]   = c;
                    got_a[k]    = opa_w[k];
                    got_b[k]    = opb_w[k];
                    got_sn[k]   = sp_next_w[k];
                    got_uf[k]   = uf_w[k];
                    got_busy[k] = busy_w[k];
                end
            end
            @(posedge clk);
            #1;
        end
        pop_req_w[0] = 1'b0;
        pop_req_w[1] = 1'b0;
        reset_n      = 1'b1;

        for (int k = 0; k < 2; k++) begin
            lat = (k == 0) ? 1 : 3;
            if (rst_c >= 0) begin
                check_eq("rst_sp_we_count", we_cnt[k], 0);
                check_eq("rst_outputs", int'({busy_w[k], done_w[k], ram_rd_w[k], sp_we_w[k], uf_w[k]}), 0);
                check_eq("rst_operands", int'({opa_w[k], opb_w[k]}), 0);
                check_eq("rst_addr_next", int'({ram_addr_w[k], sp_next_w[k]}), 0);
            end else begin
                exp_cyc = err ? 2 : 2 + need * lat;
                check_eq("done_cycle", done_c[k], exp_cyc);
                check_eq("operand_a", int'(got_a[k]), int'(ea));
                check_eq("operand_b", int'(got_b[k]), int'(eb));
                check_eq("underflow", int'(got_uf[k]), int'(err));
                check_eq("busy_at_done", int'(got_busy[k]), 1);
                check_eq("sp_we_count", we_cnt[k], err ? 0 : 1);
                check_eq("ram_rd_cycles", rd_cnt[k], err ? 0 : need * lat);
                if (!err) begin
                    check_eq("sp_next", int'(got_sn[k]), int'(sp_i) - need);
                    check_eq("ram_addr_top", first_addr[k], int'(sp_i) - 1);
                    check_eq("ram_addr_last", last_addr[k], int'(sp_i) - need);
                end
                check_eq("underflow_sticky", int'(uf_w[k]), int'(err));
            end
        end

        if (rst_c >= 0) begin
            exp_a = 8'h00; exp_b = 8'h00; exp_uf = 1'b0;
        end else begin
            exp_a = ea; exp_b = eb; exp_uf = err;
        end
    endtask

    initial begin
        logic [7:0] rsp;
        reset_n      = 1'b0;
        pop_req_w[0] = 1'b0;
        pop_req_w[1] = 1'b0;
        pop_two      = 1'b0;
        sp           = 8'h00;
        for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
        exp_a = 8'h00; exp_b = 8'h00; exp_uf = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset_n = 1'b1;
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            check_eq("reset_outputs", int'({busy_w[k], done_w[k], ram_rd_w[k], sp_we_w[k], uf_w[k]}), 0);
            check_eq("reset_operands", int'({opa_w[k], opb_w[k]}), 0);
        end
        @(posedge clk);
        #1;

        mem[0] = 8'h05; mem[1] = 8'h2A;
        run_pop(8'd2, 1'b0, 16'h0, 16'h0, -1);
        run_pop(8'd2, 1'b1, 16'h0, 16'h0, -1);
        run_pop(8'd0, 1'b0, 16'h0, 16'h0, -1);
        run_pop(8'd1, 1'b1, 16'h0, 16'h0, -1);
        run_pop(8'd1, 1'b0, 16'h0, 16'h0, -1);
        mem[8'hFE] = 8'h77;
        run_pop(8'hFF, 1'b0, 16'h0, 16'h0, -1);
        run_pop(8'd5, 1'b1, 16'h0018, 16'h0108, -1);
        run_pop(8'd3, 1'b1, 16'h0, 16'h0, 2);
        run_pop(8'd3, 1'b0, 16'h0, 16'h0, -1);

        for (int t = 0; t < 40; t++) begin
            if ($urandom_range(0, 3) == 0) begin
                case ($urandom_range(0, 3))
                    0:       rsp = 8'h00;
                    1:       rsp = 8'h01;
                    2:       rsp = 8'h02;
                    default: rsp = 8'hFF;
                endcase
            end else begin
                rsp = 8'($urandom_range(0, 255));
            end
            if (rsp >= 8'd1) mem[rsp - 8'd1] = 8'($urandom);
            if (rsp >= 8'd2) mem[rsp - 8'd2] = 8'($urandom);
            run_pop(rsp, 1'($urandom_range(0, 1)), 16'h0, 16'h0, -1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
